// File: rtl/fir_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : fir_pkg
// Purpose  : Shared widths, tap count and default coefficients for the
//            exercise4_fir 4-tap low-pass filter.
// Contents : NB_INPUT  - input sample width, S(8,7)
//            NB_COEF   - coefficient width, S(8,7)
//            NB_PROD   - full-precision product width, S(16,14)
//            NB_ADD    - quantized product width, S(10,8)
//            NB_OUTPUT - output width, S(12,8)
//            N_TAPS    - number of filter taps
//            H*_DEFAULT- default coefficients (0.5, 0.25, 0.125, 0.0625)
// Config   : FIR_ROUND_EN (used by fir_tap_mult) selects round-half-up
//            quantization instead of floor truncation.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package fir_pkg;

  localparam int NB_INPUT  = 8;
  localparam int NB_COEF   = 8;
  localparam int NB_PROD   = NB_INPUT + NB_COEF;
  localparam int NB_ADD    = 10;
  localparam int NB_OUTPUT = 12;
  localparam int N_TAPS    = 4;

  // Bits discarded when going from S(16,14) to S(10,8).
  localparam int Q_SHIFT   = NB_PROD - NB_ADD;

  localparam logic signed [NB_COEF-1:0] H0_DEFAULT = 8'sd64;
  localparam logic signed [NB_COEF-1:0] H1_DEFAULT = 8'sd32;
  localparam logic signed [NB_COEF-1:0] H2_DEFAULT = 8'sd16;
  localparam logic signed [NB_COEF-1:0] H3_DEFAULT = 8'sd8;

endpackage : fir_pkg
`default_nettype wire

// File: rtl/fir_tap_mult.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : fir_tap_mult
// Purpose  : One FIR tap: full-precision signed multiply followed by
//            quantization from S(16,14) down to S(10,8). Purely combinational.
// Ports    : i_sample [NB_INPUT-1:0]  signed delayed sample, S(8,7)
//            i_coef   [NB_COEF-1:0]   signed coefficient, S(8,7)
//            o_q      [NB_ADD-1:0]    signed quantized product, S(10,8)
// Config   : FIR_ROUND_EN defined   -> round half-up (add 2^5, then shift)
//            FIR_ROUND_EN undefined -> floor (arithmetic shift only)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module fir_tap_mult
  import fir_pkg::*;
(
  input  logic signed [NB_INPUT-1:0] i_sample,
  input  logic signed [NB_COEF-1:0]  i_coef,
  output logic signed [NB_ADD-1:0]   o_q
);

  logic signed [NB_PROD-1:0] w_prod;
  logic signed [NB_PROD-1:0] w_biased;
  logic                      w_unused_lsbs;

  assign w_prod = i_sample * i_coef;

`ifdef FIR_ROUND_EN
  // |product| <= 2^14, so adding 2^5 cannot overflow 16 bits.
  assign w_biased = w_prod + NB_PROD'(1 << (Q_SHIFT - 1));
`else
  assign w_biased = w_prod;
`endif

  // Taking the upper bits of a two's-complement value is an arithmetic
  // shift right, i.e. floor division by 2^Q_SHIFT.
  assign o_q           = w_biased[NB_PROD-1:Q_SHIFT];
  assign w_unused_lsbs = ^w_biased[Q_SHIFT-1:0];

endmodule : fir_tap_mult
`default_nettype wire

// File: rtl/exercise4_fir.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : exercise4_fir
// Purpose  : 4-tap direct-form fixed-point FIR low-pass filter with constant
//            coefficients. One sample in and one registered sample out per
//            clock; no handshake.
// Ports    : clk               rising-edge clock
//            rst               asynchronous active-high reset
//            x [NB_INPUT-1:0]  signed input sample, S(8,7)
//            y [NB_OUTPUT-1:0] signed registered output, S(12,8)
// Params   : H0..H3 - raw S(8,7) tap coefficients
// Config   : FIR_ROUND_EN selects round-half-up quantization in each tap
//            (see fir_tap_mult); widths and latency are unchanged.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module exercise4_fir
  import fir_pkg::*;
#(
  parameter logic signed [NB_COEF-1:0] H0 = H0_DEFAULT,
  parameter logic signed [NB_COEF-1:0] H1 = H1_DEFAULT,
  parameter logic signed [NB_COEF-1:0] H2 = H2_DEFAULT,
  parameter logic signed [NB_COEF-1:0] H3 = H3_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [NB_INPUT-1:0]  x,
  output logic signed [NB_OUTPUT-1:0] y
);

  localparam logic signed [NB_COEF-1:0] C_COEF [N_TAPS] = '{H0, H1, H2, H3};

  logic signed [NB_INPUT-1:0]  r_delay [N_TAPS];
  logic signed [NB_ADD-1:0]    w_q     [N_TAPS];
  logic signed [NB_OUTPUT-1:0] w_sum;

  // Delay line: r_delay[0] holds the newest sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_TAPS; k++) begin
        r_delay[k] <= '0;
      end
    end else begin
      r_delay[0] <= x;
      for (int k = 1; k < N_TAPS; k++) begin
        r_delay[k] <= r_delay[k-1];
      end
    end
  end

  generate
    for (genvar k = 0; k < N_TAPS; k++) begin : g_tap
      fir_tap_mult u_mult (
        .i_sample (r_delay[k]),
        .i_coef   (C_COEF[k]),
        .o_q      (w_q[k])
      );
    end
  endgenerate

  // Four S(10,8) terms need only two guard bits; the sum cannot overflow.
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < N_TAPS; k++) begin
      w_sum = w_sum + {{(NB_OUTPUT-NB_ADD){w_q[k][NB_ADD-1]}}, w_q[k]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y <= '0;
    end else begin
      y <= w_sum;
    end
  end

endmodule : exercise4_fir
`default_nettype wire

// File: tb/tb_exercise4_fir.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_exercise4_fir
// Purpose  : Scoreboard bench for exercise4_fir. Two instances run in
//            lockstep: default coefficients, and all coefficients = -128.
//            Stimulus pushes expected outputs from an arithmetic reference
//            model; a monitor pops and compares after every rising edge.
// Config   : honours FIR_ROUND_EN in its reference model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_exercise4_fir;

  logic               clk;
  logic               rst;
  logic signed [7:0]  x1;
  logic signed [7:0]  x2;
  logic signed [11:0] y1;
  logic signed [11:0] y2;

  int checks = 0;
  int errors = 0;

  int q_exp1[$];
  int q_exp2[$];

  int hist1 [4];
  int hist2 [4];
  int coef1 [4] = '{64, 32, 16, 8};
  int coef2 [4] = '{-128, -128, -128, -128};

  exercise4_fir u_dut1 (
    .clk (clk),
    .rst (rst),
    .x   (x1),
    .y   (y1)
  );

  exercise4_fir #(
    .H0 (-8'sd128),
    .H1 (-8'sd128),
    .H2 (-8'sd128),
    .H3 (-8'sd128)
  ) u_dut2 (
    .clk (clk),
    .rst (rst),
    .x   (x2),
    .y   (y2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Real-valued quantization to 1/256: floor(p/64), or floor((p+32)/64).
  function automatic int quant(input int p);
    int v;
    v = p;
`ifdef FIR_ROUND_EN
    v = v + 32;
`endif
    if (v >= 0) return v / 64;
    else        return -((-v + 63) / 64);
  endfunction

  function automatic int model(input int h [4], input int c [4]);
    int s;
    s = 0;
    for (int k = 0; k < 4; k++) s += quant(h[k] * c[k]);
    return s;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One stimulus cycle, applied at the falling edge ahead of the next capture.
  task automatic cycle(input int xa, input int xb, input bit r);
    @(negedge clk);
    rst = r;
    x1  = 8'(xa);
    x2  = 8'(xb);
    if (r) begin
      for (int k = 0; k < 4; k++) begin
        hist1[k] = 0;
        hist2[k] = 0;
      end
      q_exp1.push_back(0);
      q_exp2.push_back(0);
    end else begin
      q_exp1.push_back(model(hist1, coef1));
      q_exp2.push_back(model(hist2, coef2));
      for (int k = 3; k > 0; k--) begin
        hist1[k] = hist1[k-1];
        hist2[k] = hist2[k-1];
      end
      hist1[0] = int'(x1);
      hist2[0] = int'(x2);
    end
  endtask

  function automatic int rnd8();
    logic signed [7:0] v;
    v = 8'($urandom_range(255));
    return int'(v);
  endfunction

  // Monitor: one output per clock, compared just after the active edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q_exp1.size() > 0) check("y_dflt", int'(y1), q_exp1.pop_front());
      if (q_exp2.size() > 0) check("y_neg128", int'(y2), q_exp2.pop_front());
    end
  end

  initial begin
    for (int k = 0; k < 4; k++) begin
      hist1[k] = 0;
      hist2[k] = 0;
    end
    rst = 1'b0;
    x1  = 8'sd55;
    x2  = 8'sd55;
    // Reset must clear outputs before any clock edge arrives.
    #1 rst = 1'b1;
    #1;
    check("reset_async_y1", int'(y1), 0);
    check("reset_async_y2", int'(y2), 0);

    // Held reset with nonzero input: outputs stay 0.
    for (int i = 0; i < 4; i++) cycle(55, 55, 1'b1);

    // Positive impulse then long zero tail.
    cycle(100, rnd8(), 1'b0);
    for (int i = 0; i < 31; i++) cycle(0, rnd8(), 1'b0);

    // Negative impulse.
    cycle(-100, 0, 1'b0);
    for (int i = 0; i < 7; i++) cycle(0, 0, 1'b0);

    // Step on default filter; extreme held input on the -128 filter.
    for (int i = 0; i < 10; i++) cycle(127, -128, 1'b0);
    for (int i = 0; i < 4; i++) cycle(-128, -128, 1'b0);

    // Random streams.
    for (int i = 0; i < 80; i++) cycle(rnd8(), rnd8(), 1'b0);

    // Mid-stream asynchronous reset during an impulse tail.
    cycle(100, 100, 1'b0);
    cycle(0, 0, 1'b0);
    cycle(0, 0, 1'b0);
    @(posedge clk);
    #3 rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      hist1[k] = 0;
      hist2[k] = 0;
    end
    #1;
    check("midreset_async_y1", int'(y1), 0);
    check("midreset_async_y2", int'(y2), 0);
    cycle(0, 0, 1'b1);
    cycle(0, 0, 1'b1);
    for (int i = 0; i < 6; i++) cycle(0, 0, 1'b0);

    // Random again after reset.
    for (int i = 0; i < 30; i++) cycle(rnd8(), rnd8(), 1'b0);

    // Let the monitor drain the scoreboard, with a bounded wait.
    for (int i = 0; i < 10 && (q_exp1.size() > 0 || q_exp2.size() > 0); i++) begin
      @(posedge clk);
      #2;
    end
    check("scoreboard_drained", q_exp1.size() + q_exp2.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_exercise4_fir
`default_nettype wire
